// File: rtl/mil1553_pkg.sv
// Shared MIL-STD-1553 receive-path types and helpers.
// Used by run_length_counter and the downstream decode stages.
package mil1553_pkg;

    // Widest run length any decode stage is expected to carry.
    localparam int unsigned RUN_LENGTH_MAX_W = 16;

    // Saturation value of a run counter of the given width.
    function automatic int unsigned run_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    typedef struct packed {
        logic [RUN_LENGTH_MAX_W-1:0] length;
        logic                        level;
        logic                        sat;
    } run_t;

endpackage

// File: rtl/majority3_filter.sv
// Registered 3-sample majority vote; rejects single-clock glitches.
// Instantiated by run_length_counter only when RUN_LENGTH_DEGLITCH_EN is defined.
module majority3_filter
    import mil1553_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic d1_q;
    logic d2_q;
    logic q_q;
    logic vote;

    always_comb begin
        vote = (i_d & d1_q) | (i_d & d2_q) | (d1_q & d2_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
            q_q  <= 1'b0;
        end else begin
            d1_q <= i_d;
            d2_q <= d1_q;
            q_q  <= vote;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/run_length_counter.sv
// Measures run lengths of the asynchronous 1553 receive line and emits one record per level change.
// Optional feature macro: RUN_LENGTH_DEGLITCH_EN inserts a majority filter ahead of edge detection.
module run_length_counter
    import mil1553_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE = 6,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_rx,
    output logic                    o_run_valid,
    output logic [COUNTER_SIZE-1:0] o_run_length,
    output logic                    o_run_level,
    output logic                    o_run_sat,
    output logic                    o_idle
);

    localparam logic [COUNTER_SIZE-1:0] CountMax = COUNTER_SIZE'(run_max(COUNTER_SIZE));

    if (SYNC_STAGES < 2) begin : g_sync_stages_check
        $fatal(1, "run_length_counter: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    s_rx;
    logic                    det_rx;
    logic                    prev_q;
    logic                    edge_det;

    logic [COUNTER_SIZE-1:0] count_q, count_d;
    logic                    primed_q, primed_d;
    logic                    valid_q, valid_d;
    logic [COUNTER_SIZE-1:0] length_q, length_d;
    logic                    level_q, level_d;
    logic                    sat_q, sat_d;
    logic                    idle_q, idle_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign s_rx = sync_q[SYNC_STAGES-1];

`ifdef RUN_LENGTH_DEGLITCH_EN
    majority3_filter u_deglitch (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (s_rx),
        .o_q   (det_rx)
    );
`else
    assign det_rx = s_rx;
`endif

    // The synchroniser and prev keep sampling while disabled so re-enable sees no stale edge.
    always_comb begin
        edge_det = det_rx ^ prev_q;
        count_d  = count_q;
        primed_d = primed_q;
        valid_d  = 1'b0;
        length_d = length_q;
        level_d  = level_q;
        sat_d    = sat_q;
        idle_d   = 1'b0;

        if (!i_enable) begin
            count_d  = '0;
            primed_d = 1'b0;
        end else begin
            idle_d = (count_q == CountMax);
            if (edge_det) begin
                count_d  = COUNTER_SIZE'(1);
                primed_d = 1'b1;
                // The first edge only marks a run start; the run before it has no known start.
                if (primed_q) begin
                    valid_d  = 1'b1;
                    length_d = count_q;
                    level_d  = prev_q;
                    sat_d    = (count_q == CountMax);
                end
            end else if (count_q != CountMax) begin
                count_d = count_q + COUNTER_SIZE'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q   <= 1'b0;
            count_q  <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            length_q <= '0;
            level_q  <= 1'b0;
            sat_q    <= 1'b0;
            idle_q   <= 1'b0;
        end else begin
            prev_q   <= det_rx;
            count_q  <= count_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            length_q <= length_d;
            level_q  <= level_d;
            sat_q    <= sat_d;
            idle_q   <= idle_d;
        end
    end

    assign o_run_valid  = valid_q;
    assign o_run_length = length_q;
    assign o_run_level  = level_q;
    assign o_run_sat    = sat_q;
    assign o_idle       = idle_q;

endmodule

// File: tb/tb_run_length_counter.sv
// Self-checking bench for run_length_counter (COUNTER_SIZE=4, SYNC_STAGES=2).
// Expectations follow RUN_LENGTH_DEGLITCH_EN when it is defined.
module tb_run_length_counter;

    localparam int unsigned CounterSize = 4;
    localparam int unsigned SyncStages  = 2;
`ifdef RUN_LENGTH_DEGLITCH_EN
    localparam int Lat = SyncStages + 3;
`else
    localparam int Lat = SyncStages + 1;
`endif

    typedef struct {
        logic [3:0] len;
        logic       level;
        logic       sat;
    } pulse_t;

    typedef struct {
        logic       en;
        logic       rx;
        int         cycles;
        logic       pulse;
        logic [3:0] len;
        logic       level;
        logic       sat;
        logic       flush;
    } seg_t;

    logic       clk;
    logic       i_rst;
    logic       i_enable;
    logic       i_rx;
    logic       o_run_valid;
    logic [3:0] o_run_length;
    logic       o_run_level;
    logic       o_run_sat;
    logic       o_idle;

    int checks   = 0;
    int failures = 0;

    pulse_t act_q[$];
    pulse_t exp_q[$];
    seg_t   segs[$];

    run_length_counter #(
        .COUNTER_SIZE (CounterSize),
        .SYNC_STAGES  (SyncStages)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_rx         (i_rx),
        .o_run_valid  (o_run_valid),
        .o_run_length (o_run_length),
        .o_run_level  (o_run_level),
        .o_run_sat    (o_run_sat),
        .o_idle       (o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample at the following falling edge.
    task automatic cyc(input logic rx, input logic en);
        pulse_t p;
        i_rx     = rx;
        i_enable = en;
        @(negedge clk);
        if (o_run_valid) begin
            p.len   = o_run_length;
            p.level = o_run_level;
            p.sat   = o_run_sat;
            act_q.push_back(p);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] len, input logic level, input logic sat);
        pulse_t p;
        p.len   = len;
        p.level = level;
        p.sat   = sat;
        exp_q.push_back(p);
    endtask

    task automatic sb_compare(input string name);
        chk({name, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("%s_len%0d", name, i), act_q[i].len, exp_q[i].len);
            chk($sformatf("%s_level%0d", name, i), act_q[i].level, exp_q[i].level);
            chk($sformatf("%s_sat%0d", name, i), act_q[i].sat, exp_q[i].sat);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    function automatic void add(input logic en, input logic rx, input int cycles,
                                input logic pulse, input logic [3:0] len, input logic level,
                                input logic sat, input logic flush);
        seg_t s;
        s.en = en; s.rx = rx; s.cycles = cycles; s.pulse = pulse;
        s.len = len; s.level = level; s.sat = sat; s.flush = flush;
        segs.push_back(s);
    endfunction

    initial begin
        int m;

        // Basic: first edge silent, second reports the 5-clock high run.
        add(1, 0, 10, 0, 0, 0, 0, 0);
        add(1, 1, 5,  0, 0, 0, 0, 0);
        add(1, 0, 8,  1, 5, 1, 0, 1);
`ifndef RUN_LENGTH_DEGLITCH_EN
        // Minimum-length runs: one pulse per clock, alternating level.
        add(1, 1, 1, 1, 8, 0, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0, 0);
        add(1, 0, 8, 1, 1, 1, 0, 1);
`endif
        // Disable mid-run, then edges every 7 clocks.
        add(1, 1, 6, 1, 8, 0, 0, 0);
        add(0, 1, 3, 0, 0, 0, 0, 0);
        add(1, 0, 7, 0, 0, 0, 0, 0);
        add(1, 1, 7, 1, 7, 0, 0, 0);
        add(1, 0, 7, 1, 7, 1, 0, 0);
        add(1, 1, 8, 1, 7, 0, 0, 1);

        // Reset state
        i_rst = 1'b1; i_enable = 1'b0; i_rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", o_run_valid, 0);
        chk("reset_length", o_run_length, 0);
        chk("reset_idle", o_idle, 0);
        i_rst = 1'b0;

        foreach (segs[i]) begin
            if (segs[i].pulse) expect_pulse(segs[i].len, segs[i].level, segs[i].sat);
            repeat (segs[i].cycles) cyc(segs[i].rx, segs[i].en);
            if (segs[i].flush) sb_compare($sformatf("table%0d", i));
        end

        // Latency from input change to pulse
        m = 0;
        do begin cyc(0, 1); m++; end while (!o_run_valid && m < 20);
        chk("latency", m, Lat);
        chk("latency_len", o_run_length, 8);
        chk("latency_level", o_run_level, 1);

        // Saturation and idle
        act_q.delete();
        for (int k = 1; k <= 20; k++) begin
            cyc(1, 1);
            if (k == Lat + 14) chk("idle_before_sat", o_idle, 0);
            if (k == Lat + 15) chk("idle_at_sat", o_idle, 1);
        end
        m = 0;
        do begin cyc(0, 1); m++; end while (!o_run_valid && m < 20);
        chk("sat_pulse_seen", o_run_valid, 1);
        chk("sat_len", o_run_length, 15);
        chk("sat_flag", o_run_sat, 1);
        chk("sat_level", o_run_level, 1);
        chk("sat_idle_on_pulse", o_idle, 1);
        cyc(0, 1);
        chk("sat_valid_drop", o_run_valid, 0);
        chk("sat_idle_clear", o_idle, 0);

        // Disable coinciding with an edge; held outputs; first edge after re-enable silent
        cyc(0, 1);
        cyc(0, 1);
        repeat (Lat - 1) cyc(1, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0);
            chk($sformatf("dis_valid%0d", k), o_run_valid, 0);
            chk($sformatf("dis_idle%0d", k), o_idle, 0);
            chk($sformatf("dis_len%0d", k), o_run_length, 15);
            chk($sformatf("dis_sat%0d", k), o_run_sat, 1);
            chk($sformatf("dis_level%0d", k), o_run_level, 1);
        end
        act_q.delete();
        cyc(1, 1);
        cyc(1, 1);
        repeat (7) cyc(0, 1);
        m = 0;
        do begin cyc(1, 1); m++; end while (!o_run_valid && m < 20);
        chk("reen_pulses", act_q.size(), 1);
        chk("reen_latency", m, Lat);
        chk("reen_len", o_run_length, 7);
        chk("reen_level", o_run_level, 0);

        // Asynchronous reset while a pulse is presented
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_valid", o_run_valid, 0);
        chk("midrst_len", o_run_length, 0);
        chk("midrst_idle", o_idle, 0);
        i_rx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        act_q.delete();
        exp_q.delete();
        repeat (4) cyc(0, 1);
        repeat (5) cyc(1, 1);
        expect_pulse(5, 1, 0);
        repeat (8) cyc(0, 1);
        sb_compare("post_reset");

        // Single-clock glitch inside a 12-clock low run
        repeat (6) cyc(1, 1);
        act_q.delete();
        expect_pulse(6, 1, 0);
        repeat (5) cyc(0, 1);
        cyc(1, 1);
        repeat (6) cyc(0, 1);
`ifdef RUN_LENGTH_DEGLITCH_EN
        expect_pulse(12, 0, 0);
`else
        expect_pulse(5, 0, 0);
        expect_pulse(1, 1, 0);
        expect_pulse(6, 0, 0);
`endif
        repeat (8) cyc(1, 1);
        sb_compare("glitch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
